// File: rtl/sms4_lin_xform.sv
// SMS4 linear transform stage (L, L', run-time rotate, pass) with valid/ready handshake.
// Define SMS4_LT_PIPE2_EN to split rotation wiring and XOR into two register stages.
module sms4_lin_xform #(
   parameter int unsigned BWIDTH = 32,
   parameter int unsigned RWIDTH = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:BWIDTH-1] in_data,
   input  logic [1:0]        in_mode,
   input  logic [RWIDTH-1:0] rot_amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:BWIDTH-1] out_data,
   output logic [1:0]        out_mode
);

   localparam int unsigned IW    = $clog2(BWIDTH);
   localparam int unsigned SW    = $clog2(BWIDTH);
   localparam int unsigned KW    = (SW > 1) ? $clog2(SW) : 1;
   localparam int unsigned NTERM = 5;

   localparam logic [1:0] MODE_L    = 2'b00;
   localparam logic [1:0] MODE_LP   = 2'b01;
   localparam logic [1:0] MODE_ROT  = 2'b10;

   typedef logic [0:BWIDTH-1] word_t;

   // Bit 0 is the MSB, so index i takes bit (i+n) mod BWIDTH: a numeric left rotate.
   function automatic word_t rotl(input word_t b, input int unsigned n);
      word_t r;
      r = '0;
      for (int unsigned i = 0; i < BWIDTH; i++) begin
         r[IW'(i)] = b[IW'((i + n) % BWIDTH)];
      end
      return r;
   endfunction

   // Barrel rotator: one conditional power-of-two rotate per amount bit.
   function automatic word_t rot_barrel(input word_t b, input logic [SW-1:0] amt);
      word_t r;
      r = b;
      for (int unsigned k = 0; k < SW; k++) begin
         if (amt[KW'(k)]) r = rotl(r, (32'd1 << k) % BWIDTH);
      end
      return r;
   endfunction

   logic [SW-1:0] amt_c;
   word_t         term_c [NTERM];

   assign amt_c = SW'(32'(rot_amt) % BWIDTH);

   // Per-mode XOR terms; unused slots are zero so every mode folds through the same 5-input XOR.
   always_comb begin
      for (int unsigned t = 0; t < NTERM; t++) term_c[t] = '0;
      case (in_mode)
         MODE_L: begin
            term_c[0] = in_data;
            term_c[1] = rotl(in_data, 2);
            term_c[2] = rotl(in_data, 10);
            term_c[3] = rotl(in_data, 18);
            term_c[4] = rotl(in_data, 24);
         end
         MODE_LP: begin
            term_c[0] = in_data;
            term_c[1] = rotl(in_data, 13);
            term_c[2] = rotl(in_data, 23);
         end
         MODE_ROT: term_c[0] = rot_barrel(in_data, amt_c);
         default:  term_c[0] = in_data;
      endcase
   end

`ifdef SMS4_LT_PIPE2_EN
   logic       s1_valid;
   logic [1:0] s1_mode;
   word_t      s1_term [NTERM];
   logic       s2_ready;
   word_t      xor_c;

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign xor_c    = s1_term[0] ^ s1_term[1] ^ s1_term[2] ^ s1_term[3] ^ s1_term[4];

   // Stage 1 holds the rotated terms, stage 2 the XOR result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_mode   <= '0;
         for (int unsigned t = 0; t < NTERM; t++) s1_term[t] <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= '0;
      end else begin
         if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= xor_c;
               out_mode <= s1_mode;
            end
         end
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_mode <= in_mode;
               for (int unsigned t = 0; t < NTERM; t++) s1_term[t] <= term_c[t];
            end
         end
      end
   end
`else
   word_t xor_c;

   assign in_ready = !out_valid || out_ready;
   assign xor_c    = term_c[0] ^ term_c[1] ^ term_c[2] ^ term_c[3] ^ term_c[4];

   // Single output register; it refills in the same cycle it drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= xor_c;
            out_mode <= in_mode;
         end
      end
   end
`endif

endmodule
